phy_rst_seq: RTL and testbench

Board-level PHY reset and bring-up sequencer for the OneTSwitch top level. It drives the shared RGMII PHY reset pin (`rgmii_phy_rstn`) and the active-high reset into the block-design MAC/switch logic (`ext_rst` side), replacing the tied-off constant. It also supervises the shared, open-drain PHY interrupt line, turning it into a synchronous event pulse plus a count for software and LEDs. It sits between the board pins and the block-design wrapper and runs on the 125 MHz fabric clock.

---
 rtl/phy_rst_seq_pkg.sv | 22 ++
 rtl/phy_rst_seq_if.sv | 34 +++
 rtl/phy_rst_seq_sync_2ff.sv | 24 ++
 rtl/phy_rst_seq.sv | 121 ++++++++++++
 tb/tb_phy_rst_seq.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/phy_rst_seq_pkg.sv
// Shared constants for the PHY reset sequencer: state encodings,
// 125 MHz default cycle counts and the saturating counter helper.
package phy_rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_WAIT   = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // 10 ms and 50 ms at 125 MHz
    localparam int unsigned DEF_RST_ASSERT_CYC  = 1_250_000;
    localparam int unsigned DEF_RST_RELEASE_CYC = 6_250_000;
    localparam int unsigned DEF_CNT_W           = 24;

    localparam int unsigned INT_CNT_W = 8;

    function automatic logic [INT_CNT_W-1:0] sat_inc(input logic [INT_CNT_W-1:0] v);
        return (v == '1) ? v : v + INT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/phy_rst_seq_if.sv
// Board-pin side of the PHY reset sequencer: request/interrupt inputs,
// reset outputs and interrupt event reporting.
interface phy_rst_seq_if;
    import phy_rst_seq_pkg::*;

    logic                 sw_rst_req;
    logic                 phy_int_n;
    logic                 phy_rstn;
    logic                 mac_rst;
    logic                 ready;
    logic                 int_pulse;
    logic [INT_CNT_W-1:0] int_cnt;

    modport master (
        output sw_rst_req,
        output phy_int_n,
        input  phy_rstn,
        input  mac_rst,
        input  ready,
        input  int_pulse,
        input  int_cnt
    );

    modport slave (
        input  sw_rst_req,
        input  phy_int_n,
        output phy_rstn,
        output mac_rst,
        output ready,
        output int_pulse,
        output int_cnt
    );

endinterface

// File: rtl/phy_rst_seq_sync_2ff.sv
// Two-flop synchroniser for asynchronous board pins; both stages reset
// to the pin's idle level INIT.
module sync_2ff #(
    parameter logic INIT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= INIT;
            q    <= INIT;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/phy_rst_seq.sv
// PHY/MAC reset bring-up sequencer with PHY interrupt edge supervision.
// All outputs are registered from the next-state decode.
module phy_rst_seq
    import phy_rst_seq_pkg::*;
#(
    parameter int unsigned RST_ASSERT_CYC  = DEF_RST_ASSERT_CYC,
    parameter int unsigned RST_RELEASE_CYC = DEF_RST_RELEASE_CYC,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input logic         clk,
    input logic         rst,
    phy_rst_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] ASSERT_LAST  = CNT_W'(RST_ASSERT_CYC - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RST_RELEASE_CYC - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 phy_rstn_q, phy_rstn_d;
    logic                 mac_rst_q, mac_rst_d;
    logic                 ready_q, ready_d;
    logic                 int_pulse_q, int_pulse_d;
    logic [INT_CNT_W-1:0] int_cnt_q, int_cnt_d;

    logic int_sync;
    logic int_prev;
    logic int_fall;

    sync_2ff #(.INIT(1'b1)) u_int_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.phy_int_n),
        .q   (int_sync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_prev <= 1'b1;
        end else begin
            int_prev <= int_sync;
        end
    end

    assign int_fall = int_prev & ~int_sync;

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        int_pulse_d = 1'b0;
        int_cnt_d   = int_cnt_q;

        case (state_q)
            ST_ASSERT: begin
                // A request here only restarts the low period
                if (bus.sw_rst_req) begin
                    cnt_d = '0;
                end else if (cnt_q == ASSERT_LAST) begin
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (bus.sw_rst_req) begin
                    state_d = ST_ASSERT;
                end else if (cnt_q == RELEASE_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (bus.sw_rst_req) begin
                    state_d = ST_ASSERT;
                end else if (int_fall) begin
                    int_pulse_d = 1'b1;
                    int_cnt_d   = sat_inc(int_cnt_q);
                end
            end
            default: begin
                state_d = ST_ASSERT;
            end
        endcase

        if (bus.sw_rst_req) begin
            int_cnt_d = '0;
        end

        phy_rstn_d = (state_d != ST_ASSERT);
        mac_rst_d  = (state_d != ST_RUN);
        ready_d    = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ASSERT;
            cnt_q       <= '0;
            phy_rstn_q  <= 1'b0;
            mac_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            int_pulse_q <= 1'b0;
            int_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phy_rstn_q  <= phy_rstn_d;
            mac_rst_q   <= mac_rst_d;
            ready_q     <= ready_d;
            int_pulse_q <= int_pulse_d;
            int_cnt_q   <= int_cnt_d;
        end
    end

    assign bus.phy_rstn  = phy_rstn_q;
    assign bus.mac_rst   = mac_rst_q;
    assign bus.ready     = ready_q;
    assign bus.int_pulse = int_pulse_q;
    assign bus.int_cnt   = int_cnt_q;

endmodule

// File: tb/tb_phy_rst_seq.sv
// Directed + randomized bench for phy_rst_seq against a timeline-based
// reference model (elapsed edges since sequence start, pin history).
module tb_phy_rst_seq;

    localparam int A = 10;
    localparam int R = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;

    phy_rst_seq_if bus();

    phy_rst_seq #(
        .RST_ASSERT_CYC  (A),
        .RST_RELEASE_CYC (R),
        .CNT_W           (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: edge index, edge at which the sequence (re)started,
    // last three sampled pin values, expected interrupt count.
    int e;
    int s;
    bit h1, h2, h3;
    bit prev_ready;
    int m_cnt;
    bit m_pulse;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic check_outputs(input bit rstn, input bit mac, input bit rdy,
                                 input bit pulse, input logic [7:0] cnt);
        chk("phy_rstn",  {7'd0, bus.phy_rstn},  {7'd0, rstn});
        chk("mac_rst",   {7'd0, bus.mac_rst},   {7'd0, mac});
        chk("ready",     {7'd0, bus.ready},     {7'd0, rdy});
        chk("int_pulse", {7'd0, bus.int_pulse}, {7'd0, pulse});
        chk("int_cnt",   bus.int_cnt,           cnt);
    endtask

    // Apply one clock of stimulus, advance the model, check all outputs.
    task automatic step(input bit req, input bit pin);
        bit exp_rdy;
        bus.sw_rst_req = req;
        bus.phy_int_n  = pin;
        @(posedge clk);
        e++;
        // A fall seen on the pin two edges ago surfaces now, if running.
        m_pulse = prev_ready && !req && h3 && !h2;
        if (req) begin
            s     = e;
            m_cnt = 0;
        end else if (m_pulse && m_cnt < 255) begin
            m_cnt++;
        end
        h3 = h2;
        h2 = h1;
        h1 = pin;
        exp_rdy    = (e - s) >= (A + R);
        prev_ready = exp_rdy;
        #1;
        check_outputs((e - s) >= A, !exp_rdy, exp_rdy, m_pulse, m_cnt[7:0]);
    endtask

    task automatic apply_reset();
        rst            = 1'b1;
        bus.sw_rst_req = 1'b0;
        bus.phy_int_n  = 1'b1;
        #1;
        check_outputs(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst        = 1'b0;
        e          = 0;
        s          = 0;
        h1         = 1'b1;
        h2         = 1'b1;
        h3         = 1'b1;
        prev_ready = 1'b0;
        m_cnt      = 0;
    endtask

    initial begin
        bus.sw_rst_req = 1'b0;
        bus.phy_int_n  = 1'b1;
        #2;
        apply_reset();

        // Reset release: 10 low, then 20 more until RUN
        repeat (A + R + 3) step(1'b0, 1'b1);

        // Three 4-cycle low pulses in RUN
        repeat (3) begin
            repeat (4) step(1'b0, 1'b0);
            repeat (4) step(1'b0, 1'b1);
        end
        chk("int_cnt_three", bus.int_cnt, 8'd3);

        repeat (60) step(1'b0, 1'($urandom_range(0, 1)));
        repeat (3) step(1'b0, 1'b1);

        // Software re-reset from RUN
        step(1'b1, 1'b1);
        chk("int_cnt_cleared", bus.int_cnt, 8'd0);
        repeat (A) step(1'b0, 1'b1);

        // Interrupt activity during WAIT is discarded
        repeat (3) begin
            repeat (4) step(1'b0, 1'b0);
            repeat (2) step(1'b0, 1'b1);
        end
        chk("int_cnt_wait", bus.int_cnt, 8'd0);
        repeat (R) step(1'b0, 1'b1);

        // Request during ASSERT extends the low period
        step(1'b1, 1'b1);
        repeat (6) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (A - 1) step(1'b0, 1'b1);
        chk("rstn_extended_low", {7'd0, bus.phy_rstn}, 8'd0);
        step(1'b0, 1'b1);
        chk("rstn_extended_rise", {7'd0, bus.phy_rstn}, 8'd1);
        repeat (R + 2) step(1'b0, 1'b1);

        // Saturation at 255 after 300 edges
        repeat (300) begin
            step(1'b0, 1'b1);
            step(1'b0, 1'b0);
        end
        repeat (4) step(1'b0, 1'b1);
        chk("int_cnt_sat", bus.int_cnt, 8'd255);

        // Falling edge surfacing in the same cycle as a request
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("collision_pulse", {7'd0, bus.int_pulse}, 8'd0);
        chk("collision_cnt", bus.int_cnt, 8'd0);
        repeat (A + R + 2) step(1'b0, 1'b1);

        // Mixed random requests and pin activity
        repeat (300) step($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)));

        // Async reset in WAIT cycle 5, then a full restart
        step(1'b1, 1'b1);
        repeat (A + 5) step(1'b0, 1'b1);
        apply_reset();
        repeat (A + R + 3) step(1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
